// File: rtl/slow_adc_scheduler.sv
// Acquisition sequencer for the slow ADC chain: configuration handshake with
// retry, periodic non-overlapping acquisition triggers, and health counters.
module slow_adc_scheduler #(
  parameter int CLOCK_FREQUENCY   = 50,
  parameter int DEFAULT_PERIOD_MS = 100,
  parameter int MIN_PERIOD_MS     = 100,
  parameter int CONFIG_TIMEOUT    = 5000000,
  parameter int ACQ_TIMEOUT       = 500000,
  parameter int MAX_RETRIES       = 3
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] period_ms,
  input  logic        period_load,
  input  logic        adc_configured,
  input  logic        adc_busy,
  input  logic        data_valid,
  output logic        start_configuration,
  output logic        start_acquisition,
  output logic        ready,
  output logic        config_error,
  output logic [2:0]  state,
  output logic [31:0] sample_count,
  output logic [15:0] acq_timeout_count,
  output logic [15:0] missed_tick_count
);

  typedef enum logic [2:0] {
    S_CONFIGURE   = 3'd0,
    S_WAIT_CONFIG = 3'd1,
    S_READY       = 3'd2,
    S_WAIT_DATA   = 3'd3,
    S_CONFIG_FAIL = 3'd4
  } state_t;

  localparam logic [31:0] TICKS_PER_MS   = 32'(CLOCK_FREQUENCY * 1000);
  localparam logic [15:0] MIN_PERIOD     = 16'(MIN_PERIOD_MS);
  localparam logic [15:0] DEFAULT_PERIOD = 16'(DEFAULT_PERIOD_MS);
  localparam logic [31:0] DEFAULT_CYCLES = 32'(DEFAULT_PERIOD_MS * CLOCK_FREQUENCY * 1000);
  localparam logic [31:0] CONFIG_LAST    = 32'(CONFIG_TIMEOUT - 1);
  localparam logic [31:0] ACQ_LAST       = 32'(ACQ_TIMEOUT - 1);
  localparam logic [7:0]  MAX_TRIES      = 8'(MAX_RETRIES);
  localparam logic [15:0] SAT16          = 16'hFFFF;

  state_t      r_state;
  logic        r_enable_meta;
  logic        r_enable_sync;
  logic [15:0] r_pending_ms;
  logic [31:0] r_period_calc;
  logic [31:0] r_period_cycles;
  logic [31:0] r_pcnt;
  logic [31:0] r_wait_cnt;
  logic [31:0] r_acq_timer;
  logic [7:0]  r_attempts;
  logic        r_start_configuration;
  logic        r_start_acquisition;
  logic        r_ready;
  logic        r_config_error;
  logic [31:0] r_sample_count;
  logic [15:0] r_acq_timeout_count;
  logic [15:0] r_missed_tick_count;

  logic        w_counting;
  logic        w_tick;
  logic [15:0] w_load_ms;

  assign w_counting = r_enable_sync && ((r_state == S_READY) || (r_state == S_WAIT_DATA));
  assign w_tick     = w_counting && (r_pcnt == (r_period_cycles - 32'd1));
  assign w_load_ms  = (period_ms < MIN_PERIOD) ? MIN_PERIOD : period_ms;

  // Two-flop synchronizer for the asynchronous enable level.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_enable_meta <= 1'b0;
      r_enable_sync <= 1'b0;
    end else begin
      r_enable_meta <= enable;
      r_enable_sync <= r_enable_meta;
    end
  end

  // Period bookkeeping: a new period is only adopted while pcnt is zero, so a
  // running period is never cut short or stretched mid-count.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_pending_ms    <= DEFAULT_PERIOD;
      r_period_calc   <= DEFAULT_CYCLES;
      r_period_cycles <= DEFAULT_CYCLES;
      r_pcnt          <= 32'd0;
    end else begin
      if (period_load) begin
        r_pending_ms <= w_load_ms;
      end
      r_period_calc <= {16'd0, r_pending_ms} * TICKS_PER_MS;
      if (!w_counting || w_tick) begin
        r_pcnt          <= 32'd0;
        r_period_cycles <= r_period_calc;
      end else begin
        r_pcnt <= r_pcnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_state               <= S_CONFIGURE;
      r_start_configuration <= 1'b0;
      r_start_acquisition   <= 1'b0;
      r_ready               <= 1'b0;
      r_config_error        <= 1'b0;
      r_wait_cnt            <= 32'd0;
      r_acq_timer           <= 32'd0;
      r_attempts            <= 8'd0;
      r_sample_count        <= 32'd0;
      r_acq_timeout_count   <= 16'd0;
      r_missed_tick_count   <= 16'd0;
    end else begin
      r_start_configuration <= 1'b0;
      r_start_acquisition   <= 1'b0;
      case (r_state)
        S_CONFIGURE: begin
          r_start_configuration <= 1'b1;
          r_wait_cnt            <= 32'd0;
          r_ready               <= 1'b0;
          r_state               <= S_WAIT_CONFIG;
        end
        S_WAIT_CONFIG: begin
          if (adc_configured) begin
            r_ready <= 1'b1;
            r_state <= S_READY;
          end else if (r_wait_cnt == CONFIG_LAST) begin
            r_attempts <= r_attempts + 8'd1;
            if ((r_attempts + 8'd1) < MAX_TRIES) begin
              r_state <= S_CONFIGURE;
            end else begin
              r_config_error <= 1'b1;
              r_state        <= S_CONFIG_FAIL;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + 32'd1;
          end
        end
        S_READY: begin
          if (w_tick) begin
            if (adc_busy) begin
              if (r_missed_tick_count != SAT16) begin
                r_missed_tick_count <= r_missed_tick_count + 16'd1;
              end
            end else begin
              r_start_acquisition <= 1'b1;
              r_acq_timer         <= 32'd0;
              r_state             <= S_WAIT_DATA;
            end
          end
        end
        S_WAIT_DATA: begin
          // A tick here is never turned into a second trigger.
          if (w_tick && (r_missed_tick_count != SAT16)) begin
            r_missed_tick_count <= r_missed_tick_count + 16'd1;
          end
          if (data_valid) begin
            r_sample_count <= r_sample_count + 32'd1;
            r_state        <= S_READY;
          end else if (r_acq_timer == ACQ_LAST) begin
            if (r_acq_timeout_count != SAT16) begin
              r_acq_timeout_count <= r_acq_timeout_count + 16'd1;
            end
            r_state <= S_READY;
          end else begin
            r_acq_timer <= r_acq_timer + 32'd1;
          end
        end
        S_CONFIG_FAIL: begin
          r_config_error <= 1'b1;
          r_ready        <= 1'b0;
        end
        default: begin
          r_state <= S_CONFIGURE;
        end
      endcase
    end
  end

  assign start_configuration = r_start_configuration;
  assign start_acquisition   = r_start_acquisition;
  assign ready               = r_ready;
  assign config_error        = r_config_error;
  assign state               = r_state;
  assign sample_count        = r_sample_count;
  assign acq_timeout_count   = r_acq_timeout_count;
  assign missed_tick_count   = r_missed_tick_count;

endmodule

// File: tb/tb_slow_adc_scheduler.sv
// Directed bench for slow_adc_scheduler with a small ADC response model.
module tb_slow_adc_scheduler;

  logic        clk_50 = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] period_ms = 16'd0;
  logic        period_load = 1'b0;
  logic        adc_configured = 1'b0;
  logic        adc_busy = 1'b0;
  logic        data_valid = 1'b0;
  logic        start_configuration;
  logic        start_acquisition;
  logic        ready;
  logic        config_error;
  logic [2:0]  state;
  logic [31:0] sample_count;
  logic [15:0] acq_timeout_count;
  logic [15:0] missed_tick_count;

  int vectors = 0;
  int fails = 0;
  int cyc = 0;
  int cfg_delay = 0;
  int dv_delay = 0;
  int cfg_cnt = 0;
  int dv_cnt = 0;
  int cfg_times[$];
  int acq_times[$];

  slow_adc_scheduler #(
    .CLOCK_FREQUENCY(1),
    .DEFAULT_PERIOD_MS(4),
    .MIN_PERIOD_MS(2),
    .CONFIG_TIMEOUT(50),
    .ACQ_TIMEOUT(100),
    .MAX_RETRIES(3)
  ) dut (
    .clk_50(clk_50),
    .reset(reset),
    .enable(enable),
    .period_ms(period_ms),
    .period_load(period_load),
    .adc_configured(adc_configured),
    .adc_busy(adc_busy),
    .data_valid(data_valid),
    .start_configuration(start_configuration),
    .start_acquisition(start_acquisition),
    .ready(ready),
    .config_error(config_error),
    .state(state),
    .sample_count(sample_count),
    .acq_timeout_count(acq_timeout_count),
    .missed_tick_count(missed_tick_count)
  );

  always #5 clk_50 = ~clk_50;

  always @(posedge clk_50) cyc <= cyc + 1;

  // ADC model and pulse monitor, all on the falling edge so the DUT samples
  // stable inputs and its registered outputs are read mid-cycle.
  always @(negedge clk_50) begin
    data_valid <= 1'b0;
    if (start_configuration) begin
      cfg_times.push_back(cyc);
      adc_configured <= 1'b0;
      cfg_cnt <= (cfg_delay > 0) ? cfg_delay - 1 : 0;
    end else if (cfg_cnt > 0) begin
      cfg_cnt <= cfg_cnt - 1;
      if (cfg_cnt == 1) adc_configured <= 1'b1;
    end
    if (start_acquisition) begin
      acq_times.push_back(cyc);
      dv_cnt <= (dv_delay > 0) ? dv_delay - 1 : 0;
    end else if (dv_cnt > 0) begin
      dv_cnt <= dv_cnt - 1;
      if (dv_cnt == 1) data_valid <= 1'b1;
    end
  end

  task automatic wait_acq(input int n, input int budget, output bit ok);
    int k = 0;
    while (acq_times.size() < n && k < budget) begin
      @(negedge clk_50);
      k++;
    end
    ok = (acq_times.size() >= n);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_50);
    vectors++; if (state !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", state); end
    vectors++; if (start_configuration !== 1'b0) begin fails++; $display("FAIL reset_start_cfg: got %b expected 0", start_configuration); end
    vectors++; if (start_acquisition !== 1'b0) begin fails++; $display("FAIL reset_start_acq: got %b expected 0", start_acquisition); end
    vectors++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", ready); end
    vectors++; if (config_error !== 1'b0) begin fails++; $display("FAIL reset_cfg_err: got %b expected 0", config_error); end
    vectors++; if (sample_count !== 32'd0) begin fails++; $display("FAIL reset_samples: got %0d expected 0", sample_count); end
    vectors++; if (acq_timeout_count !== 16'd0) begin fails++; $display("FAIL reset_timeouts: got %0d expected 0", acq_timeout_count); end
    vectors++; if (missed_tick_count !== 16'd0) begin fails++; $display("FAIL reset_missed: got %0d expected 0", missed_tick_count); end
  endtask

  task automatic test_config_success();
    int n = 0;
    cfg_delay = 20;
    reset = 1'b0;
    @(negedge clk_50);
    vectors++; if (start_configuration !== 1'b1) begin fails++; $display("FAIL first_cfg_pulse: got %b expected 1", start_configuration); end
    while (state !== 3'd2 && n < 200) begin
      @(negedge clk_50);
      n++;
    end
    vectors++; if (n !== 20) begin fails++; $display("FAIL cfg_ready_latency: got %0d expected 20", n); end
    vectors++; if (cfg_times.size() !== 1) begin fails++; $display("FAIL cfg_pulse_count: got %0d expected 1", cfg_times.size()); end
    vectors++; if (state !== 3'd2) begin fails++; $display("FAIL cfg_state: got %0d expected 2", state); end
    vectors++; if (ready !== 1'b1) begin fails++; $display("FAIL cfg_ready: got %b expected 1", ready); end
  endtask

  task automatic test_periodic();
    int t_en;
    bit ok;
    dv_delay = 30;
    t_en = cyc;
    enable = 1'b1;
    wait_acq(5, 21000, ok);
    vectors++; if (ok !== 1'b1) begin fails++; $display("FAIL periodic_pulses: got %0d expected 5", acq_times.size()); end
    if (ok) begin
      vectors++; if (acq_times[0] - (t_en + 1) !== 4001) begin fails++; $display("FAIL first_trigger_delay: got %0d expected 4001", acq_times[0] - (t_en + 1)); end
      for (int i = 1; i < 5; i++) begin
        vectors++; if (acq_times[i] - acq_times[i-1] !== 4000) begin fails++; $display("FAIL trigger_spacing_%0d: got %0d expected 4000", i, acq_times[i] - acq_times[i-1]); end
      end
    end
    repeat (40) @(negedge clk_50);
    vectors++; if (sample_count !== 32'd5) begin fails++; $display("FAIL periodic_samples: got %0d expected 5", sample_count); end
    vectors++; if (missed_tick_count !== 16'd0) begin fails++; $display("FAIL periodic_missed: got %0d expected 0", missed_tick_count); end
    vectors++; if (state !== 3'd2) begin fails++; $display("FAIL periodic_state: got %0d expected 2", state); end
  endtask

  task automatic test_busy_and_timeout();
    int last;
    int n0;
    int t;
    int k = 0;
    bit ok;
    n0 = acq_times.size();
    last = acq_times[n0-1];
    adc_busy = 1'b1;
    while (cyc < last + 4002) @(negedge clk_50);
    vectors++; if (missed_tick_count !== 16'd1) begin fails++; $display("FAIL busy_missed: got %0d expected 1", missed_tick_count); end
    vectors++; if (acq_times.size() !== n0) begin fails++; $display("FAIL busy_no_pulse: got %0d pulses expected %0d", acq_times.size(), n0); end
    adc_busy = 1'b0;
    dv_delay = 0;
    wait_acq(n0 + 1, 4100, ok);
    vectors++; if (ok !== 1'b1) begin fails++; $display("FAIL post_busy_pulse: got %0d expected %0d", acq_times.size(), n0 + 1); end
    if (ok) begin
      t = acq_times[n0];
      vectors++; if (t - last !== 8000) begin fails++; $display("FAIL post_busy_spacing: got %0d expected 8000", t - last); end
      while (state !== 3'd2 && k < 300) begin
        @(negedge clk_50);
        k++;
      end
      vectors++; if (cyc - t !== 100) begin fails++; $display("FAIL acq_timeout_latency: got %0d expected 100", cyc - t); end
      vectors++; if (acq_timeout_count !== 16'd1) begin fails++; $display("FAIL acq_timeout_count: got %0d expected 1", acq_timeout_count); end
      vectors++; if (sample_count !== 32'd5) begin fails++; $display("FAIL timeout_samples: got %0d expected 5", sample_count); end
    end
  endtask

  task automatic test_period_clamp();
    int n0;
    int t;
    bit ok;
    dv_delay = 30;
    n0 = acq_times.size();
    t = acq_times[n0-1];
    period_ms = 16'd1;
    period_load = 1'b1;
    @(negedge clk_50);
    period_load = 1'b0;
    wait_acq(n0 + 3, 8300, ok);
    vectors++; if (ok !== 1'b1) begin fails++; $display("FAIL clamp_pulses: got %0d expected %0d", acq_times.size(), n0 + 3); end
    if (ok) begin
      vectors++; if (acq_times[n0] - t !== 4000) begin fails++; $display("FAIL clamp_old_period: got %0d expected 4000", acq_times[n0] - t); end
      vectors++; if (acq_times[n0+1] - acq_times[n0] !== 2000) begin fails++; $display("FAIL clamp_min_period_a: got %0d expected 2000", acq_times[n0+1] - acq_times[n0]); end
      vectors++; if (acq_times[n0+2] - acq_times[n0+1] !== 2000) begin fails++; $display("FAIL clamp_min_period_b: got %0d expected 2000", acq_times[n0+2] - acq_times[n0+1]); end
    end
    period_ms = 16'd10;
    period_load = 1'b1;
    @(negedge clk_50);
    period_load = 1'b0;
    wait_acq(n0 + 5, 12300, ok);
    vectors++; if (ok !== 1'b1) begin fails++; $display("FAIL long_period_pulses: got %0d expected %0d", acq_times.size(), n0 + 5); end
    if (ok) begin
      vectors++; if (acq_times[n0+3] - acq_times[n0+2] !== 2000) begin fails++; $display("FAIL long_period_old: got %0d expected 2000", acq_times[n0+3] - acq_times[n0+2]); end
      vectors++; if (acq_times[n0+4] - acq_times[n0+3] !== 10000) begin fails++; $display("FAIL long_period_new: got %0d expected 10000", acq_times[n0+4] - acq_times[n0+3]); end
    end
  endtask

  task automatic test_reset_in_wait_data();
    int ncfg;
    int nacq;
    vectors++; if (state !== 3'd3) begin fails++; $display("FAIL pre_reset_state: got %0d expected 3", state); end
    dv_delay = 0;
    cfg_delay = 20;
    ncfg = cfg_times.size();
    nacq = acq_times.size();
    reset = 1'b1;
    @(negedge clk_50);
    reset = 1'b0;
    vectors++; if (state !== 3'd0) begin fails++; $display("FAIL mid_reset_state: got %0d expected 0", state); end
    vectors++; if (sample_count !== 32'd0) begin fails++; $display("FAIL mid_reset_samples: got %0d expected 0", sample_count); end
    vectors++; if (acq_timeout_count !== 16'd0) begin fails++; $display("FAIL mid_reset_timeouts: got %0d expected 0", acq_timeout_count); end
    vectors++; if (missed_tick_count !== 16'd0) begin fails++; $display("FAIL mid_reset_missed: got %0d expected 0", missed_tick_count); end
    vectors++; if (ready !== 1'b0) begin fails++; $display("FAIL mid_reset_ready: got %b expected 0", ready); end
    @(negedge clk_50);
    vectors++; if (start_configuration !== 1'b1) begin fails++; $display("FAIL reconfig_pulse: got %b expected 1", start_configuration); end
    repeat (60) @(negedge clk_50);
    vectors++; if (cfg_times.size() !== ncfg + 1) begin fails++; $display("FAIL reconfig_count: got %0d expected %0d", cfg_times.size(), ncfg + 1); end
    vectors++; if (acq_times.size() !== nacq) begin fails++; $display("FAIL stale_trigger: got %0d pulses expected %0d", acq_times.size(), nacq); end
    vectors++; if (sample_count !== 32'd0) begin fails++; $display("FAIL stale_sample: got %0d expected 0", sample_count); end
    vectors++; if (state !== 3'd2) begin fails++; $display("FAIL reconfig_state: got %0d expected 2", state); end
  endtask

  task automatic test_config_fail();
    int nacq;
    cfg_delay = 0;
    cfg_times.delete();
    nacq = acq_times.size();
    reset = 1'b1;
    repeat (2) @(negedge clk_50);
    reset = 1'b0;
    repeat (200) @(negedge clk_50);
    vectors++; if (cfg_times.size() !== 3) begin fails++; $display("FAIL fail_cfg_pulses: got %0d expected 3", cfg_times.size()); end
    if (cfg_times.size() >= 3) begin
      vectors++; if (cfg_times[1] - cfg_times[0] !== 51) begin fails++; $display("FAIL retry_spacing_1: got %0d expected 51", cfg_times[1] - cfg_times[0]); end
      vectors++; if (cfg_times[2] - cfg_times[1] !== 51) begin fails++; $display("FAIL retry_spacing_2: got %0d expected 51", cfg_times[2] - cfg_times[1]); end
    end
    vectors++; if (state !== 3'd4) begin fails++; $display("FAIL fail_state: got %0d expected 4", state); end
    vectors++; if (config_error !== 1'b1) begin fails++; $display("FAIL fail_cfg_err: got %b expected 1", config_error); end
    vectors++; if (ready !== 1'b0) begin fails++; $display("FAIL fail_ready: got %b expected 0", ready); end
    repeat (4500) @(negedge clk_50);
    vectors++; if (acq_times.size() !== nacq) begin fails++; $display("FAIL fail_no_trigger: got %0d pulses expected %0d", acq_times.size(), nacq); end
    vectors++; if (cfg_times.size() !== 3) begin fails++; $display("FAIL fail_terminal: got %0d pulses expected 3", cfg_times.size()); end
    vectors++; if (config_error !== 1'b1) begin fails++; $display("FAIL fail_sticky: got %b expected 1", config_error); end
  endtask

  initial begin
    test_reset();
    test_config_success();
    test_periodic();
    test_busy_and_timeout();
    test_period_clamp();
    test_reset_in_wait_data();
    test_config_fail();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/slow_adc_scheduler.md
# slow_adc_scheduler

Sequencer for the slow acquisition chain: two ADS869x voltage ADCs plus the MAX31855K thermocouple. After reset it runs the ADC configuration handshake with timeout and bounded retry. It then issues periodic, non-overlapping `start_acquisition` pulses at a runtime-programmable rate. It supervises completion of each conversion and exports health counters to the host register bank.

## Interface
Parameters:
- `CLOCK_FREQUENCY`, 50: clock rate in MHz; ticks per ms = `CLOCK_FREQUENCY*1000`.
- `DEFAULT_PERIOD_MS`, 100: acquisition period in ms after reset.
- `MIN_PERIOD_MS`, 100: lower clamp on the period (thermocouple max rate is 10 Hz).
- `CONFIG_TIMEOUT`, 5000000: cycles to wait for `adc_configured`.
- `ACQ_TIMEOUT`, 500000: cycles to wait for `data_valid` after a trigger.
- `MAX_RETRIES`, 3: number of configuration attempts before declaring failure.

Ports:
- `clk_50` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: acquisition enable level; asynchronous, passed through a 2-FF synchronizer.
- `period_ms` in 16: requested period.
- `period_load` in 1: one-cycle strobe that latches `period_ms`.
- `adc_configured` in 1: level from ADC, high once configuration is done.
- `adc_busy` in 1: OR of all converter busy signals.
- `data_valid` in 1: AND of all converter valid signals.
- `start_configuration` out 1: one-cycle pulse.
- `start_acquisition` out 1: one-cycle pulse.
- `ready` out 1: high in READY or WAIT_DATA.
- `config_error` out 1: sticky until reset.
- `state` out 3: FSM state encoding.
- `sample_count` out 32: completed acquisitions.
- `acq_timeout_count` out 16: acquisitions that timed out; saturating.
- `missed_tick_count` out 16: skipped ticks; saturating.

## Operation
- States and encodings: CONFIGURE=0, WAIT_CONFIG=1, READY=2, WAIT_DATA=3, CONFIG_FAIL=4.
- CONFIGURE: assert `start_configuration` for 1 cycle, clear the wait counter, go to WAIT_CONFIG.
- WAIT_CONFIG:
  - `adc_configured`=1 → READY.
  - Wait counter reaching `CONFIG_TIMEOUT-1` → increment attempt count.
  - If attempts < `MAX_RETRIES` → CONFIGURE, otherwise → CONFIG_FAIL.
- CONFIG_FAIL: terminal; `config_error`=1; no acquisition pulses. Exit only by reset.
- Period counter (`pcnt`, 32 b):
  - Counts while `enable_sync`=1 in READY or WAIT_DATA; cleared when `enable_sync`=0.
  - A tick occurs when `pcnt == period_cycles-1`; `pcnt` then returns to 0.
- READY:
  - On a tick with `adc_busy`=0: assert `start_acquisition`, clear the acquisition timer, go to WAIT_DATA.
  - On a tick with `adc_busy`=1: increment `missed_tick_count`, stay in READY.
- WAIT_DATA:
  - `data_valid`=1 → increment `sample_count` (wraps at 2^32), go to READY.
  - Acquisition timer reaching `ACQ_TIMEOUT-1` → increment `acq_timeout_count`, go to READY.
  - A tick while in WAIT_DATA → increment `missed_tick_count`; never issue a second trigger.
  - `data_valid` and timeout in the same cycle: count it as a valid sample; timeout is ignored.
- Period update:
  - `period_load` latches `max(period_ms, MIN_PERIOD_MS)` into a pending register.
  - `period_cycles = pending * CLOCK_FREQUENCY*1000` is computed over 32 bits and registered 1 cycle later.
  - The new value is applied only when `pcnt` is 0: at a tick, or while disabled.
  - A load in the same cycle as a tick takes effect at the following tick.
- `enable` falling in WAIT_DATA: finish the WAIT_DATA transaction normally; `pcnt` clears.
- Reset mid-operation: all counters are cleared, and the FSM returns to CONFIGURE, which re-issues `start_configuration`.

## Timing
- Reset values:
  - `start_configuration`=0, `start_acquisition`=0, `ready`=0, `config_error`=0.
  - All counters 0; `state`=CONFIGURE.
  - `period_cycles = DEFAULT_PERIOD_MS*CLOCK_FREQUENCY*1000`.
- `start_configuration` rises on the first edge after reset deasserts.
- All outputs are registered.
- First `start_acquisition`: P+1 cycles after the first edge that samples `enable`=1 in READY, with P=`period_cycles`.
- Subsequent pulses are exactly P cycles apart while `adc_busy`=0 and each acquisition completes before the next tick.
- `data_valid` → READY on the next edge; `sample_count` is updated on that same edge.
- Saturating counters hold at 0xFFFF.

## Test plan
Bench parameters: `CLOCK_FREQUENCY`=1, `MIN_PERIOD_MS`=2, `DEFAULT_PERIOD_MS`=4, `CONFIG_TIMEOUT`=50, `ACQ_TIMEOUT`=100, `MAX_RETRIES`=3.
- Config success: release reset; model raises `adc_configured` 20 cycles after the pulse → exactly one `start_configuration` pulse; `state`=READY; `ready`=1.
- Config failure: `adc_configured` held at 0 → 3 pulses spaced 51 cycles apart; `state`=4; `config_error`=1; `enable`=1 produces no `start_acquisition`.
- Periodic trigger: model returns `data_valid` 30 cycles after each trigger; `enable`=1 → first pulse 4001 cycles after enable is sampled, then every 4000 cycles; `sample_count`=5 after 5 periods.
- Busy and timeout: `adc_busy`=1 at a tick → `missed_tick_count`=1 and no pulse; no `data_valid` after a trigger → return to READY after 100 cycles and `acq_timeout_count`=1.
- Period clamp: `period_load` with `period_ms`=1 → spacing becomes 2000 cycles from the second tick after the load; `period_ms`=10 → 10000 cycles.
- Reset in WAIT_DATA: assert `reset` 1 cycle → counters 0, `state`=0, new `start_configuration` pulse, no stale `start_acquisition`.
